rtc_read_sequencer: RTL

- Bus master that reads the nine time, date and timer registers from the external RTC chip over its multiplexed address/data bus.
- Each captured byte is presented on a one-cycle write port: En, sel_reg, data_save.
- Feeds the VGA register bank, i.e. the writer side of that bank's interface.
- One burst per start pulse; triggered by the top-level control FSM, typically once per refresh period.

---
 rtl/rtc_read_sequencer_pkg.sv | 37 +++
 rtl/rtc_addr_rom.sv | 25 ++
 rtl/rtc_read_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rtc_read_sequencer_pkg.sv
// Shared constants for the RTC read sequencer: RTC register addresses,
// register-bank indices and sequencer state encoding.
package rtc_read_sequencer_pkg;

    localparam int NUM_REGS = 9;

    localparam logic [7:0] ADDR_SEG    = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_HORA   = 8'h23;
    localparam logic [7:0] ADDR_DAY    = 8'h24;
    localparam logic [7:0] ADDR_MONTH  = 8'h25;
    localparam logic [7:0] ADDR_YEAR   = 8'h26;
    localparam logic [7:0] ADDR_SEG_T  = 8'h41;
    localparam logic [7:0] ADDR_MIN_T  = 8'h42;
    localparam logic [7:0] ADDR_HORA_T = 8'h43;

    localparam logic [3:0] IDX_SEG    = 4'd0;
    localparam logic [3:0] IDX_MIN    = 4'd1;
    localparam logic [3:0] IDX_HORA   = 4'd2;
    localparam logic [3:0] IDX_DAY    = 4'd3;
    localparam logic [3:0] IDX_MONTH  = 4'd4;
    localparam logic [3:0] IDX_YEAR   = 4'd5;
    localparam logic [3:0] IDX_SEG_T  = 4'd6;
    localparam logic [3:0] IDX_MIN_T  = 4'd7;
    localparam logic [3:0] IDX_HORA_T = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP1,
        READ,
        GAP2,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/rtc_addr_rom.sv
// Register-bank index to RTC register address lookup.
module rtc_addr_rom
    import rtc_read_sequencer_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] addr
);

    always_comb begin
        addr = 8'h00;
        unique case (idx)
            IDX_SEG:    addr = ADDR_SEG;
            IDX_MIN:    addr = ADDR_MIN;
            IDX_HORA:   addr = ADDR_HORA;
            IDX_DAY:    addr = ADDR_DAY;
            IDX_MONTH:  addr = ADDR_MONTH;
            IDX_YEAR:   addr = ADDR_YEAR;
            IDX_SEG_T:  addr = ADDR_SEG_T;
            IDX_MIN_T:  addr = ADDR_MIN_T;
            IDX_HORA_T: addr = ADDR_HORA_T;
            default:    addr = 8'h00;
        endcase
    end

endmodule

// File: rtl/rtc_read_sequencer.sv
// Burst reader for the nine RTC time/date/timer registers; each captured
// byte is written to the register bank through a one-cycle En port.
module rtc_read_sequencer
    import rtc_read_sequencer_pkg::*;
#(
    parameter int T_PHASE = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       En,
    output logic [3:0] sel_reg,
    output logic [7:0] data_save,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] LAST = 8'(T_PHASE - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] rom_addr;
    logic       phase_end;

    logic [7:0] ad_out_d, data_d;
    logic [3:0] sel_d;
    logic       ad_oe_d, ad_sel_d, cs_n_d, rd_n_d, wr_n_d;
    logic       en_d, busy_d, done_d;

    rtc_addr_rom u_rom (
        .idx  (idx_d),
        .addr (rom_addr)
    );

    assign phase_end = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = ADDR;
                idx_d   = 4'd0;
            end
            ADDR: if (phase_end) state_d = GAP1;
            GAP1: if (phase_end) state_d = READ;
            READ: if (phase_end) begin
                state_d = GAP2;
                cap_d   = ad_in;
            end
            GAP2: if (phase_end) state_d = STORE;
            STORE: begin
                if (idx_q == IDX_HORA_T) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    // Outputs are decoded from the next state so the registered
    // outputs line up with the state they belong to.
    always_comb begin
        ad_out_d = ad_out;
        ad_oe_d  = 1'b0;
        ad_sel_d = 1'b0;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        en_d     = 1'b0;
        sel_d    = sel_reg;
        data_d   = data_save;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            ADDR: begin
                ad_out_d = rom_addr;
                ad_oe_d  = 1'b1;
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                busy_d   = 1'b1;
            end
            GAP1: begin
                ad_oe_d = (cnt_d == 8'd0);
                busy_d  = 1'b1;
            end
            READ: begin
                ad_sel_d = 1'b1;
                cs_n_d   = 1'b0;
                rd_n_d   = 1'b0;
                busy_d   = 1'b1;
            end
            GAP2: busy_d = 1'b1;
            STORE: begin
                en_d   = 1'b1;
                sel_d  = idx_q;
                data_d = cap_d;
                busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            idx_q     <= 4'd0;
            cap_q     <= 8'h00;
            ad_out    <= 8'h00;
            ad_oe     <= 1'b0;
            ad_sel    <= 1'b0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            En        <= 1'b0;
            sel_reg   <= 4'd0;
            data_save <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cap_q     <= cap_d;
            ad_out    <= ad_out_d;
            ad_oe     <= ad_oe_d;
            ad_sel    <= ad_sel_d;
            cs_n      <= cs_n_d;
            rd_n      <= rd_n_d;
            wr_n      <= wr_n_d;
            En        <= en_d;
            sel_reg   <= sel_d;
            data_save <= data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
